shift_sub_divider: RTL and testbench

Sequential restoring divider, the inverse of the team's shift-and-add accumulator multiplier. It computes an unsigned quotient and remainder one bit per clock using shift-and-subtract, under a start/busy/done handshake. It sits beside the multiplier in the arithmetic datapath. The same output gating scheme lets both blocks share a result bus.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_trial_sub.sv | 14 +
 rtl/shift_sub_divider.sv | 131 +++++++++++++
 tb/tb_shift_sub_divider.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the shift-and-subtract divider.
// Holds the default operand width, the FSM state type and the counter width.
package div_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int CNT_W              = $clog2(DEFAULT_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor for the divider.
// Returns the difference and a borrow that is high when the minuend is smaller.
module div_trial_sub #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] minuend_i,
    input  logic [WIDTH-1:0] subtrahend_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    assign {borrow_o, diff_o} = {1'b0, minuend_i} - {1'b0, subtrahend_i};

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one quotient bit per clock under a start/busy/done handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes in one cycle.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    input  logic                  i_q_oe,
    input  logic                  i_r_oe,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder,
    output logic                  o_div_by_zero
);

    localparam int CntW = $clog2(DATA_WIDTH);

    state_t                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0] div_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic                  dz_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] quoRes_q;
    logic [DATA_WIDTH-1:0] remRes_q;
    logic                  dzRes_q;

    logic [DATA_WIDTH:0]   remShift_d;
    logic [DATA_WIDTH:0]   diff_d;
    logic                  borrow_d;
    logic [DATA_WIDTH-1:0] remStep_d;
    logic [DATA_WIDTH-1:0] quoStep_d;
    logic                  diffMsbUnused;

    // The partial remainder stays below the divisor, so N bits hold it between steps;
    // only the shifted trial value needs the extra bit.
    assign remShift_d = {rem_q, quo_q[DATA_WIDTH-1]};

    div_trial_sub #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_trial_sub (
        .minuend_i   (remShift_d),
        .subtrahend_i({1'b0, div_q}),
        .diff_o      (diff_d),
        .borrow_o    (borrow_d)
    );

    assign diffMsbUnused = diff_d[DATA_WIDTH];
    assign remStep_d     = borrow_d ? remShift_d[DATA_WIDTH-1:0] : diff_d[DATA_WIDTH-1:0];
    assign quoStep_d     = {quo_q[DATA_WIDTH-2:0], ~borrow_d};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            quoRes_q <= '0;
            remRes_q <= '0;
            dzRes_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (i_start) begin
                        div_q <= i_divisor;
                        quo_q <= i_dividend;
                        rem_q <= '0;
                        cnt_q <= '0;
                        dz_q  <= (i_divisor == '0);
`ifdef DIV_ZERO_FAST_EN
                        if (i_divisor == '0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            quoRes_q <= '1;
                            remRes_q <= i_dividend;
                            dzRes_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= CALC;
                        busy_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= remStep_d;
                    quo_q <= quoStep_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        quoRes_q <= quoStep_d;
                        remRes_q <= remStep_d;
                        dzRes_q  <= dz_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_quotient    = i_q_oe ? quoRes_q : '0;
    assign o_remainder   = i_r_oe ? remRes_q : '0;
    assign o_div_by_zero = dzRes_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed self-checking bench for shift_sub_divider (8-bit operands).
// Honours DIV_ZERO_FAST_EN for the expected divide-by-zero latency.
module tb_shift_sub_divider;

    localparam int N = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [N-1:0] i_dividend = '0;
    logic [N-1:0] i_divisor = '0;
    logic         i_q_oe = 1'b1;
    logic         i_r_oe = 1'b1;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_quotient;
    logic [N-1:0] o_remainder;
    logic         o_div_by_zero;

    int total = 0;
    int bad   = 0;

    shift_sub_divider #(
        .DATA_WIDTH(N)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .i_q_oe       (i_q_oe),
        .i_r_oe       (i_r_oe),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one start and waits for o_done, reporting the done cycle (0 on timeout)
    // and how many cycles o_busy was seen high. Returns at the negedge of the done cycle.
    task automatic applyStimulus(input logic [N-1:0] dvd, input logic [N-1:0] dvs, input bit chained,
                                 output int doneCyc, output int busyCnt);
        if (!chained) @(negedge i_clk);
        i_dividend = dvd;
        i_divisor  = dvs;
        i_start    = 1'b1;
        @(posedge i_clk);
        doneCyc = 0;
        busyCnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_busy) busyCnt++;
            if (o_done) begin
                doneCyc = c;
                break;
            end
        end
    endtask

    int doneCyc, busyCnt, doneCnt;
    logic [N-1:0] capQ, capR;
    logic capDz;

    initial begin
        @(negedge i_clk);
        #1;
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_quo", o_quotient, 0);
        checkOutput("rst_rem", o_remainder, 0);
        checkOutput("rst_dz", o_div_by_zero, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        applyStimulus(8'd100, 8'd7, 1'b0, doneCyc, busyCnt);
        checkOutput("d100_cyc", doneCyc, 9);
        checkOutput("d100_busy", busyCnt, 8);
        checkOutput("d100_quo", o_quotient, 14);
        checkOutput("d100_rem", o_remainder, 2);
        checkOutput("d100_dz", o_div_by_zero, 0);
        @(negedge i_clk);
        checkOutput("d100_pulse", o_done, 0);

        i_q_oe = 1'b0;
        #1;
        checkOutput("oe_q0_quo", o_quotient, 0);
        checkOutput("oe_q0_rem", o_remainder, 2);
        i_q_oe = 1'b1;
        i_r_oe = 1'b0;
        #1;
        checkOutput("oe_r0_quo", o_quotient, 14);
        checkOutput("oe_r0_rem", o_remainder, 0);
        i_r_oe = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("oe_hold_quo", o_quotient, 14);
        checkOutput("oe_hold_rem", o_remainder, 2);

        applyStimulus(8'd255, 8'd1, 1'b0, doneCyc, busyCnt);
        checkOutput("d255_cyc", doneCyc, 9);
        checkOutput("d255_quo", o_quotient, 255);
        checkOutput("d255_rem", o_remainder, 0);
        applyStimulus(8'd5, 8'd9, 1'b1, doneCyc, busyCnt);
        checkOutput("b2b_cyc", doneCyc, 9);
        checkOutput("b2b_busy", busyCnt, 8);
        checkOutput("b2b_quo", o_quotient, 0);
        checkOutput("b2b_rem", o_remainder, 5);

        applyStimulus(8'd200, 8'd0, 1'b0, doneCyc, busyCnt);
`ifdef DIV_ZERO_FAST_EN
        checkOutput("dz_cyc", doneCyc, 1);
        checkOutput("dz_busy", busyCnt, 0);
`else
        checkOutput("dz_cyc", doneCyc, 9);
        checkOutput("dz_busy", busyCnt, 8);
`endif
        checkOutput("dz_quo", o_quotient, 255);
        checkOutput("dz_rem", o_remainder, 200);
        checkOutput("dz_flag", o_div_by_zero, 1);
        repeat (2) @(negedge i_clk);
        checkOutput("dz_flag_hold", o_div_by_zero, 1);

        // Start pulses during CALC must be ignored; held results persist until the new DONE.
        @(negedge i_clk);
        i_dividend = 8'd50;
        i_divisor  = 8'd3;
        i_start    = 1'b1;
        @(posedge i_clk);
        doneCnt = 0;
        doneCyc = 0;
        capQ = '0;
        capR = '0;
        capDz = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge i_clk);
            i_start = (c <= 6) ? c[0] : 1'b0;
            if (c == 1) begin
                checkOutput("ign_held_quo", o_quotient, 255);
                checkOutput("ign_held_dz", o_div_by_zero, 1);
            end
            if (o_done) begin
                doneCnt++;
                if (doneCyc == 0) begin
                    doneCyc = c;
                    capQ = o_quotient;
                    capR = o_remainder;
                    capDz = o_div_by_zero;
                end
            end
        end
        checkOutput("ign_done_cnt", doneCnt, 1);
        checkOutput("ign_cyc", doneCyc, 9);
        checkOutput("ign_quo", capQ, 16);
        checkOutput("ign_rem", capR, 2);
        checkOutput("ign_dz", capDz, 0);

        @(negedge i_clk);
        i_dividend = 8'd77;
        i_divisor  = 8'd5;
        i_start    = 1'b1;
        @(posedge i_clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
        end
        checkOutput("rst_mid_busy_before", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", o_busy, 0);
        checkOutput("rst_mid_done", o_done, 0);
        checkOutput("rst_mid_quo", o_quotient, 0);
        checkOutput("rst_mid_rem", o_remainder, 0);
        checkOutput("rst_mid_dz", o_div_by_zero, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(8'd77, 8'd5, 1'b0, doneCyc, busyCnt);
        checkOutput("d77_cyc", doneCyc, 9);
        checkOutput("d77_quo", o_quotient, 15);
        checkOutput("d77_rem", o_remainder, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
